// File: rtl/f5_pkg.sv
// Shared constants, FSM encoding and requantization helper for the F5 fully-connected stage.
package f5_pkg;

  localparam int unsigned WD        = 8;
  localparam int unsigned NW        = 256;
  localparam int unsigned NUM       = 120;
  localparam int unsigned AW        = 24;
  localparam int unsigned SHIFT_DEF = 7;
  localparam bit          RELU_DEF  = 1'b1;
  localparam int unsigned TW        = 8;
  localparam int unsigned PW        = 2 * WD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [TW-1:0] num;
    logic [TW-1:0] addr;
  } wtag_t;

  // Round-half-up arithmetic shift, optional ReLU, then saturate to WD bits.
  function automatic logic signed [WD-1:0] requant(input logic signed [AW-1:0] x,
                                                   input int unsigned        shift,
                                                   input bit                 relu);
    logic signed [AW:0] xe;
    logic signed [AW:0] rnd;
    logic signed [AW:0] r;
    logic signed [AW:0] hi;
    logic signed [AW:0] lo;
    xe  = {x[AW-1], x};
    rnd = (AW+1)'(1) << (shift - 1);
    r   = (xe + rnd) >>> shift;
    hi  = (AW+1)'((1 << (WD - 1)) - 1);
    lo  = ~hi;
    if (relu && (r < 0)) r = '0;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return WD'(r);
  endfunction

endpackage

// File: rtl/f5_fc_mac_if.sv
// Activation write port, tagged weight stream and tagged result port of the F5 stage.
interface f5_fc_mac_if;
  import f5_pkg::*;

  logic                 i_act_en;
  logic [TW-1:0]        i_act_addr;
  logic signed [WD-1:0] i_act_data;
  logic                 i_w_en;
  logic [TW-1:0]        i_w_num;
  logic [TW-1:0]        i_w_addr;
  logic signed [WD-1:0] i_weight;
  logic                 o_f5_en;
  logic [TW-1:0]        o_f5_num;
  logic signed [WD-1:0] o_f5_data;
  logic signed [AW-1:0] o_f5_acc;
  logic                 o_busy;
  logic                 o_frame_done;
  logic                 o_seq_err;

  modport master (
    output i_act_en, i_act_addr, i_act_data, i_w_en, i_w_num, i_w_addr, i_weight,
    input  o_f5_en, o_f5_num, o_f5_data, o_f5_acc, o_busy, o_frame_done, o_seq_err
  );

  modport slave (
    input  i_act_en, i_act_addr, i_act_data, i_w_en, i_w_num, i_w_addr, i_weight,
    output o_f5_en, o_f5_num, o_f5_data, o_f5_acc, o_busy, o_frame_done, o_seq_err
  );

endinterface

// File: rtl/f5_act_ram.sv
// Activation vector store: one synchronous write port, one asynchronous read port, no reset.
module f5_act_ram
  import f5_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [TW-1:0]        waddr_i,
  input  logic signed [WD-1:0] wdata_i,
  input  logic [TW-1:0]        raddr_i,
  output logic signed [WD-1:0] rdata_c_o
);

  logic signed [WD-1:0] mem_q [NW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Same-cycle read of a location being written returns the old contents.
  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/f5_fc_mac.sv
// F5 fully-connected MAC: per-neuron signed dot product over the weight stream,
// requantized and emitted as one tagged result per neuron.
module f5_fc_mac
  import f5_pkg::*;
#(
  parameter int unsigned SHIFT = SHIFT_DEF,
  parameter bit          RELU  = RELU_DEF
) (
  input  logic        i_sclk,
  input  logic        i_rst,
  f5_fc_mac_if.slave  bus
);

  localparam logic [TW-1:0] LAST_ADDR = TW'(NW - 1);
  localparam logic [TW-1:0] LAST_NUM  = TW'(NUM);
  localparam wtag_t         START_TAG = '{num: TW'(1), addr: '0};

  state_e               state_q, state_d;
  wtag_t                exp_q, exp_d, base_c;
  logic                 tag_bad_c, w_acc_c, act_we_c;
  logic                 seq_err_q;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic signed [WD-1:0] act_rd_c;

  logic                 v1_q, first1_q, last1_q;
  logic [TW-1:0]        num1_q;
  logic signed [PW-1:0] prod1_q;

  logic signed [AW-1:0] acc_q, sum_c;
  logic                 f5_en_q;
  logic [TW-1:0]        f5_num_q;
  logic signed [WD-1:0] f5_data_q;
  logic signed [AW-1:0] f5_acc_q;

  // Activation writes are only honoured between frames.
  assign act_we_c = bus.i_act_en & ~busy_q;

  f5_act_ram u_act_ram (
    .clk_i     (i_sclk),
    .we_i      (act_we_c),
    .waddr_i   (bus.i_act_addr),
    .wdata_i   (bus.i_act_data),
    .raddr_i   (bus.i_w_addr),
    .rdata_c_o (act_rd_c)
  );

  // In IDLE only the frame-start tag is legal; mid-frame weights are accepted even when mistagged.
  assign base_c    = (state_q == IDLE) ? START_TAG : exp_q;
  assign tag_bad_c = bus.i_w_en && ({bus.i_w_num, bus.i_w_addr} != base_c);
  assign w_acc_c   = bus.i_w_en && ((state_q != IDLE) || !tag_bad_c);

  always_comb begin
    exp_d = exp_q;
    if (w_acc_c) begin
      if (base_c.addr == LAST_ADDR) begin
        exp_d.addr = '0;
        exp_d.num  = (base_c.num == LAST_NUM) ? TW'(1) : base_c.num + TW'(1);
      end else begin
        exp_d.addr = base_c.addr + TW'(1);
        exp_d.num  = base_c.num;
      end
    end
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      exp_q     <= START_TAG;
      seq_err_q <= 1'b0;
    end else begin
      exp_q     <= exp_d;
      seq_err_q <= seq_err_q | tag_bad_c;
    end
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (w_acc_c) state_d = RUN;
      RUN:     if (f5_en_q && (f5_num_q == LAST_NUM)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    if (state_d != IDLE) busy_d = 1'b1;
    if (state_d == DONE) frame_done_d = 1'b1;
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Stage 1: product and position tags of the accepted weight.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      num1_q   <= '0;
      prod1_q  <= '0;
    end else begin
      v1_q <= w_acc_c;
      if (w_acc_c) begin
        prod1_q  <= PW'(act_rd_c) * PW'(bus.i_weight);
        first1_q <= (bus.i_w_addr == '0);
        last1_q  <= (bus.i_w_addr == LAST_ADDR);
        num1_q   <= bus.i_w_num;
      end
    end
  end

  assign sum_c = first1_q ? AW'(prod1_q) : acc_q + AW'(prod1_q);

  // Stage 2: accumulate; bubbles leave the accumulator untouched.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      acc_q     <= '0;
      f5_en_q   <= 1'b0;
      f5_num_q  <= '0;
      f5_data_q <= '0;
      f5_acc_q  <= '0;
    end else begin
      f5_en_q <= v1_q && last1_q;
      if (v1_q) begin
        acc_q <= sum_c;
        if (last1_q) begin
          f5_num_q  <= num1_q;
          f5_acc_q  <= sum_c;
          f5_data_q <= requant(sum_c, SHIFT, RELU);
        end
      end
    end
  end

  assign bus.o_f5_en      = f5_en_q;
  assign bus.o_f5_num     = f5_num_q;
  assign bus.o_f5_data    = f5_data_q;
  assign bus.o_f5_acc     = f5_acc_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_seq_err    = seq_err_q;

endmodule
